// File: rtl/input_event_conditioner.sv
// Button/rotary front end: 2-FF sync, per-input debounce, edge-to-event coding,
// per-source pending flags, lowest-code arbiter and a 4-entry event FIFO.
// Ports:
//   Clock, Reset            : system clock, async active-high reset
//   iBtnNorth..iRotB        : raw asynchronous switch/rotary inputs
//   iEventAck               : pop FIFO head (ignored when empty)
//   iClearOverrun           : clear sticky overrun flag
//   oEventValid/oEventCode  : FIFO non-empty / head event code (1..7)
//   oBtnLevel               : debounced {center,west,east,south,north}
//   oOverrun                : sticky, an event was dropped
module input_event_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ROT_CYCLES      = 5000,
    parameter int CNT_W           = 20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iBtnNorth,
    input  logic       iBtnSouth,
    input  logic       iBtnEast,
    input  logic       iBtnWest,
    input  logic       iRotCenter,
    input  logic       iRotA,
    input  logic       iRotB,
    input  logic       iEventAck,
    input  logic       iClearOverrun,
    output logic       oEventValid,
    output logic [2:0] oEventCode,
    output logic [4:0] oBtnLevel,
    output logic       oOverrun
);

    localparam int NIN = 7;
    localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ROT_LIM = CNT_W'(ROT_CYCLES - 1);

    // Bit order: 0 N, 1 S, 2 E, 3 W, 4 C, 5 A, 6 B
    logic [NIN-1:0] raw;
    assign raw = {iRotB, iRotA, iRotCenter, iBtnWest,
                  iBtnEast, iBtnSouth, iBtnNorth};

    logic [NIN-1:0]   sync1_q, sync2_q;
    logic [NIN-1:0]   lvl_q, lvl_d;
    logic [5:0]       lvl_prev_q;
    logic [CNT_W-1:0] cnt_q [NIN];
    logic [CNT_W-1:0] cnt_d [NIN];

    logic [6:0]       pend_q, pend_d;
    logic [6:0]       ev, gnt;
    logic [5:0]       rise;
    logic             ovr_q, ovr_d;

    logic [2:0]       mem_q [4];
    logic [1:0]       wr_ptr_q, rd_ptr_q;
    logic [2:0]       fcnt_q, fcnt_d;
    logic             push, pop, can_push, found;
    logic [2:0]       push_code;

    // Debounce: counter runs only while synced value disagrees with level
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < NIN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == ((i < 5) ? DB_LIM : ROT_LIM)) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edges of the debounced levels; rotation direction from filtered B
    assign rise  = lvl_q[5:0] & ~lvl_prev_q;
    assign ev    = {rise[5] & lvl_q[6], rise[5] & ~lvl_q[6], rise[4:0]};

    assign pop      = iEventAck & (fcnt_q != 3'd0);
    assign can_push = (fcnt_q != 3'd4) | pop;

    // Lowest-code pending source wins the FIFO slot
    always_comb begin
        gnt       = '0;
        push      = 1'b0;
        push_code = 3'd0;
        found     = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (!found && pend_q[i]) begin
                found = 1'b1;
                if (can_push) begin
                    gnt[i]    = 1'b1;
                    push      = 1'b1;
                    push_code = 3'(i + 1);
                end
            end
        end
    end

    // An event hitting an already-set flag is dropped, even if that flag
    // is being granted this same cycle.
    assign pend_d = (pend_q & ~gnt) | (ev & ~pend_q);
    assign ovr_d  = (|(ev & pend_q)) | (ovr_q & ~iClearOverrun);

    always_comb begin
        fcnt_d = fcnt_q;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 3'd1;
            2'b01:   fcnt_d = fcnt_q - 3'd1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= '0;
            end
            pend_q     <= '0;
            ovr_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q[5:0];
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_code;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            fcnt_q     <= fcnt_d;
        end
    end

    assign oEventValid = (fcnt_q != 3'd0);
    assign oEventCode  = oEventValid ? mem_q[rd_ptr_q] : 3'd0;
    assign oBtnLevel   = lvl_q[4:0];
    assign oOverrun    = ovr_q;

endmodule

// File: tb/tb_input_event_conditioner.sv
// Scoreboard bench for input_event_conditioner (DEBOUNCE_CYCLES=4, ROT_CYCLES=2).
// Stimulus pushes expected codes; a negedge monitor acks and compares.
module tb_input_event_conditioner;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iBtnNorth, iBtnSouth, iBtnEast, iBtnWest, iRotCenter;
    logic       iRotA, iRotB;
    logic       iEventAck, iClearOverrun;
    logic       oEventValid;
    logic [2:0] oEventCode;
    logic [4:0] oBtnLevel;
    logic       oOverrun;

    logic       stim_ack, mon_ack;
    bit         auto_ack = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         exp_q[$];

    assign iEventAck = stim_ack | mon_ack;

    always #5 Clock = ~Clock;

    input_event_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .ROT_CYCLES     (2),
        .CNT_W          (20)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iBtnNorth    (iBtnNorth),
        .iBtnSouth    (iBtnSouth),
        .iBtnEast     (iBtnEast),
        .iBtnWest     (iBtnWest),
        .iRotCenter   (iRotCenter),
        .iRotA        (iRotA),
        .iRotB        (iRotB),
        .iEventAck    (iEventAck),
        .iClearOverrun(iClearOverrun),
        .oEventValid  (oEventValid),
        .oEventCode   (oEventCode),
        .oBtnLevel    (oBtnLevel),
        .oOverrun     (oOverrun)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick(1);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic set_btns(input logic v);
        iBtnNorth  = v;
        iBtnSouth  = v;
        iBtnEast   = v;
        iBtnWest   = v;
        iRotCenter = v;
    endtask

    // Monitor: ack and compare whenever an event is presented
    initial begin
        mon_ack = 1'b0;
        forever begin
            @(negedge Clock);
            mon_ack = 1'b0;
            if (auto_ack && oEventValid && !Reset) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", int'(oEventCode), 0);
                end else begin
                    chk("event_code", int'(oEventCode), exp_q.pop_front());
                end
                mon_ack = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        Reset         = 1'b1;
        set_btns(1'b0);
        iRotA         = 1'b0;
        iRotB         = 1'b0;
        stim_ack      = 1'b0;
        iClearOverrun = 1'b0;
        tick(2);
        chk("reset_state",
            int'({oEventValid, oEventCode, oBtnLevel, oOverrun}), 0);
        Reset = 1'b0;
        tick(2);

        // 1. North press latency and ack
        iBtnNorth = 1'b1;
        n = 0;
        while (!oEventValid && n < 50) begin
            tick(1);
            n++;
        end
        chk("north_latency", n, 8);
        exp_q.push_back(1);
        auto_ack = 1'b1;
        tick(1);
        chk("valid_after_ack", int'(oEventValid), 0);
        chk("north_level", int'(oBtnLevel), 1);
        tick(12);
        iBtnNorth = 1'b0;
        tick(10);
        chk("north_release", int'(oBtnLevel), 0);

        // 2. East glitch of 3 cycles
        iBtnEast = 1'b1;
        tick(3);
        iBtnEast = 1'b0;
        seen = 0;
        repeat (12) begin
            tick(1);
            seen |= int'(oBtnLevel[2]) | int'(oEventValid);
        end
        chk("east_glitch", seen, 0);

        // 3. Rotary CW then CCW
        iRotA = 1'b1;
        exp_q.push_back(6);
        tick(8);
        iRotA = 1'b0;
        tick(6);
        iRotB = 1'b1;
        tick(6);
        iRotA = 1'b1;
        exp_q.push_back(7);
        tick(8);
        iRotA = 1'b0;
        tick(6);
        iRotB = 1'b0;
        tick(6);
        drain();

        // 4. Five simultaneous presses, FIFO fills, center waits
        auto_ack = 1'b0;
        set_btns(1'b1);
        tick(20);
        chk("full_valid", int'(oEventValid), 1);
        chk("full_head", int'(oEventCode), 1);
        chk("levels_all", int'(oBtnLevel), 31);
        chk("no_overrun", int'(oOverrun), 0);
        for (int c = 1; c <= 5; c++) exp_q.push_back(c);
        auto_ack = 1'b1;
        drain();
        chk("no_overrun_after", int'(oOverrun), 0);
        set_btns(1'b0);
        tick(10);

        // 5. Overrun on center while its flag is pending
        auto_ack = 1'b0;
        set_btns(1'b1);
        tick(20);
        iRotCenter = 1'b0;
        tick(10);
        chk("center_low", int'(oBtnLevel[4]), 0);
        chk("overrun_pre", int'(oOverrun), 0);
        iRotCenter = 1'b1;
        tick(12);
        chk("overrun_set", int'(oOverrun), 1);
        iClearOverrun = 1'b1;
        tick(1);
        iClearOverrun = 1'b0;
        chk("overrun_clear", int'(oOverrun), 0);
        set_btns(1'b0);
        for (int c = 1; c <= 5; c++) exp_q.push_back(c);
        auto_ack = 1'b1;
        drain();
        tick(3);
        chk("empty_after_5", int'(oEventValid), 0);
        tick(8);

        // 6. Reset with queued events and half-debounced press
        auto_ack = 1'b0;
        iBtnNorth = 1'b1;
        iBtnSouth = 1'b1;
        iBtnEast  = 1'b1;
        tick(15);
        chk("pre_reset_valid", int'(oEventValid), 1);
        iBtnWest = 1'b1;
        tick(4);
        Reset = 1'b1;
        #1;
        chk("reset_async",
            int'({oEventValid, oEventCode, oBtnLevel, oOverrun}), 0);
        set_btns(1'b0);
        tick(3);
        Reset = 1'b0;
        tick(20);
        chk("post_reset_valid", int'(oEventValid), 0);
        chk("post_reset_level", int'(oBtnLevel), 0);
        auto_ack = 1'b1;

        // 7. Ack while empty, then a normal press
        stim_ack = 1'b1;
        tick(3);
        stim_ack = 1'b0;
        tick(1);
        chk("empty_ack_valid", int'(oEventValid), 0);
        iBtnSouth = 1'b1;
        exp_q.push_back(2);
        tick(10);
        drain();
        iBtnSouth = 1'b0;
        tick(10);
        chk("final_valid", int'(oEventValid), 0);
        chk("final_overrun", int'(oOverrun), 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
